// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 32-bit ALU between two requesters.
// Optional grant statistics outputs are enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid0,
  input  logic        ReqValid1,
  output logic        ReqReady0,
  output logic        ReqReady1,
  input  logic [3:0]  ReqOp0,
  input  logic [3:0]  ReqOp1,
  input  logic [31:0] ReqA0,
  input  logic [31:0] ReqA1,
  input  logic [31:0] ReqB0,
  input  logic [31:0] ReqB1,
  input  logic [4:0]  ReqShamt0,
  input  logic [4:0]  ReqShamt1,
  output logic        RespValid0,
  output logic        RespValid1,
  input  logic        RespReady0,
  input  logic        RespReady1,
  output logic [31:0] RespResult,
  output logic        RespZero,
  output logic [3:0]  AluControl,
  output logic [31:0] AluA,
  output logic [31:0] AluB,
  output logic [4:0]  AluShamt,
  input  logic [31:0] AluResult,
  input  logic        AluZero,
`ifdef ALU_ARB_STATS_EN
  output logic [15:0] GrantCount0,
  output logic [15:0] GrantCount1,
`endif
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int         DEFAULT_CYCLES = 1;
  localparam logic [3:0] MUL_LOAD       = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DEF_LOAD       = 4'(DEFAULT_CYCLES - 1);
  localparam logic [3:0] OP_MUL         = 4'd8;
  localparam logic [3:0] OP_BAD         = 4'd15;

  logic [1:0]  state;
  logic        prio;
  logic        owner;
  logic [3:0]  cnt;
  logic        grant0;
  logic        grant1;
  logic        owner_ready;
  logic [3:0]  sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [4:0]  sel_shamt;

  // Handshakes: a request transfers on a clock edge where ReqValidN and ReqReadyN
  // are both high; a response retires on an edge where RespValidN and RespReadyN
  // are both high. Valid must not depend on ready; ready is only offered in IDLE.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (ReqValid0 && ReqValid1) begin
        grant0 = !prio;
        grant1 = prio;
      end else begin
        grant0 = ReqValid0;
        grant1 = ReqValid1;
      end
    end
  end

  always_comb begin
    sel_op    = grant1 ? ReqOp1    : ReqOp0;
    sel_a     = grant1 ? ReqA1     : ReqA0;
    sel_b     = grant1 ? ReqB1     : ReqB0;
    sel_shamt = grant1 ? ReqShamt1 : ReqShamt0;
  end

  assign ReqReady0   = grant0;
  assign ReqReady1   = grant1;
  assign RespValid0  = (state == RESP) && !owner;
  assign RespValid1  = (state == RESP) && owner;
  assign owner_ready = owner ? RespReady1 : RespReady0;
  assign dbg_state   = state;

  // The ALU drive registers double as the latched request, so the ALU inputs
  // only change on an accept edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      prio       <= 1'b0;
      owner      <= 1'b0;
      cnt        <= 4'd0;
      RespResult <= 32'd0;
      RespZero   <= 1'b0;
      AluControl <= 4'd0;
      AluA       <= 32'd0;
      AluB       <= 32'd0;
      AluShamt   <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            AluControl <= sel_op;
            AluA       <= sel_a;
            AluB       <= sel_b;
            AluShamt   <= sel_shamt;
            owner      <= grant1;
            cnt        <= (sel_op == OP_MUL) ? MUL_LOAD : DEF_LOAD;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (AluControl == OP_BAD) begin
              RespResult <= 32'd0;
              RespZero   <= 1'b1;
            end else begin
              RespResult <= AluResult;
              RespZero   <= AluZero;
            end
            state <= RESP;
          end
        end
        RESP: begin
          if (owner_ready) begin
            prio  <= !owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      GrantCount0 <= 16'd0;
      GrantCount1 <= 16'd0;
    end else begin
      if (grant0 && (GrantCount0 != 16'hFFFF)) GrantCount0 <= GrantCount0 + 16'd1;
      if (grant1 && (GrantCount1 != 16'hFFFF)) GrantCount1 <= GrantCount1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, corner-case sequences and a
// randomized run against a transaction-level reference model.
module tb_alu_arbiter;
  localparam int MUL = 3;

  logic        clk, reset;
  logic        req_valid0, req_valid1, req_ready0, req_ready1;
  logic [3:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic [4:0]  req_shamt0, req_shamt1;
  logic        resp_valid0, resp_valid1, resp_ready0, resp_ready1;
  logic [31:0] resp_result;
  logic        resp_zero;
  logic [3:0]  alu_control;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_shamt;
  logic        alu_zero;
  logic [1:0]  dbg_state;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_count0, grant_count1;
`endif

  int checks = 0;
  int errors = 0;
  int g0 = 0;
  int g1 = 0;

  // Stand-in ALU; op 15 deliberately yields a nonzero value.
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return a * b;
      4'd9:  return b << sh;
      4'd10: return b >> sh;
      4'd11: return $signed(b) >>> sh;
      4'd12: return b << a[4:0];
      4'd13: return b >> a[4:0];
      4'd14: return {b[15:0], 16'h0000};
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  function automatic logic [31:0] exp_res(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    return (op == 4'd15) ? 32'd0 : alu_ref(op, a, b, sh);
  endfunction

  assign alu_result = alu_ref(alu_control, alu_a, alu_b, alu_shamt);
  assign alu_zero   = (alu_result == 32'd0);

  alu_arbiter #(.MUL_CYCLES(MUL)) dut (
    .Clk(clk), .Reset(reset),
    .ReqValid0(req_valid0), .ReqValid1(req_valid1),
    .ReqReady0(req_ready0), .ReqReady1(req_ready1),
    .ReqOp0(req_op0), .ReqOp1(req_op1),
    .ReqA0(req_a0), .ReqA1(req_a1), .ReqB0(req_b0), .ReqB1(req_b1),
    .ReqShamt0(req_shamt0), .ReqShamt1(req_shamt1),
    .RespValid0(resp_valid0), .RespValid1(resp_valid1),
    .RespReady0(resp_ready0), .RespReady1(resp_ready1),
    .RespResult(resp_result), .RespZero(resp_zero),
    .AluControl(alu_control), .AluA(alu_a), .AluB(alu_b), .AluShamt(alu_shamt),
    .AluResult(alu_result), .AluZero(alu_zero),
`ifdef ALU_ARB_STATS_EN
    .GrantCount0(grant_count0), .GrantCount1(grant_count1),
`endif
    .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input int who, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    if (who == 0) begin
      req_valid0 = v; req_op0 = op; req_a0 = a; req_b0 = b; req_shamt0 = sh;
    end else begin
      req_valid1 = v; req_op1 = op; req_a1 = a; req_b1 = b; req_shamt1 = sh;
    end
  endtask

  task automatic set_rr(input int who, input logic v);
    if (who == 0) resp_ready0 = v;
    else resp_ready1 = v;
  endtask

  function automatic logic get_ready(input int who);
    return (who == 0) ? req_ready0 : req_ready1;
  endfunction

  function automatic logic get_rv(input int who);
    return (who == 0) ? resp_valid0 : resp_valid1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " ready0"}, req_ready0, 0);
    check({tag, " ready1"}, req_ready1, 0);
    check({tag, " resp_valid0"}, resp_valid0, 0);
    check({tag, " resp_valid1"}, resp_valid1, 0);
    check({tag, " resp_result"}, resp_result, 0);
    check({tag, " resp_zero"}, resp_zero, 0);
    check({tag, " alu_control"}, alu_control, 0);
    check({tag, " alu_a"}, alu_a, 0);
    check({tag, " alu_b"}, alu_b, 0);
    check({tag, " alu_shamt"}, alu_shamt, 0);
    check({tag, " state"}, dbg_state, 0);
`ifdef ALU_ARB_STATS_EN
    check({tag, " grant_count0"}, grant_count0, 0);
    check({tag, " grant_count1"}, grant_count1, 0);
`endif
  endtask

  // One isolated transaction from an idle arbiter, with latency and hold checks.
  task automatic run_txn(input int who, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic [31:0] res,
                         input logic zero, input int lat_exp, input string tag);
    int lat;
    bit got;
    @(negedge clk);
    drive_req(who, 1'b1, op, a, b, sh);
    #1;
    check({tag, " grant"}, get_ready(who), 1);
    check({tag, " other_grant"}, get_ready(1 - who), 0);
    @(posedge clk);
    #1;
    drive_req(who, 1'b0, 4'($urandom), $urandom, $urandom, 5'($urandom));
    if (who == 0) g0++; else g1++;
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (get_rv(who)) got = 1;
      else begin
        check({tag, " hold_a"}, alu_a, a);
        check({tag, " hold_b"}, alu_b, b);
      end
    end
    check({tag, " latency"}, lat, lat_exp);
    check({tag, " result"}, resp_result, res);
    check({tag, " zero"}, resp_zero, zero);
    check({tag, " alu_op_held"}, alu_control, op);
    check({tag, " other_resp"}, get_rv(1 - who), 0);
    @(negedge clk);
    set_rr(who, 1'b1);
    @(posedge clk);
    #1;
    set_rr(who, 1'b0);
    check({tag, " resp_done"}, get_rv(who), 0);
  endtask

  task automatic wait_resp(input int who, input logic [31:0] res, input string tag);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      #1;
      if (get_rv(who)) got = 1;
    end
    check({tag, " resp_seen"}, got, 1);
    check({tag, " resp_result"}, resp_result, res);
  endtask

  typedef struct {
    int          who;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        zero;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  // Reference model state for the random phase.
  logic [32:0] exp_q[$];
  bit          m_busy, m_owner, m_prio;
  int          m_elapsed, m_lat;
  logic [3:0]  last_op;
  logic [31:0] last_a, last_b;
  logic [4:0]  last_sh;
  bit          pv[2];
  logic [3:0]  p_op[2];
  logic [31:0] p_a[2], p_b[2];
  logic [4:0]  p_sh[2];

  function automatic logic [3:0] pick_op();
    int r = $urandom_range(0, 19);
    if (r < 15) return 4'(r);
    if (r < 18) return 4'd8;
    return 4'd15;
  endfunction

  initial begin
    int order[$];
    logic [31:0] held;
    bit e0, e1, ev;
    int w;

    vecs[0]  = '{0, 4'd0,  32'd5,        32'd7,        5'd0,  32'd12,        1'b0, 1};
    vecs[1]  = '{1, 4'd1,  32'd9,        32'd9,        5'd0,  32'd0,         1'b1, 1};
    vecs[2]  = '{0, 4'd2,  32'hF0,       32'h0F,       5'd0,  32'd0,         1'b1, 1};
    vecs[3]  = '{1, 4'd3,  32'hF0,       32'h0F,       5'd0,  32'hFF,        1'b0, 1};
    vecs[4]  = '{0, 4'd8,  32'hFFFFFFFD, 32'd4,        5'd0,  32'hFFFFFFF4,  1'b0, MUL};
    vecs[5]  = '{1, 4'd15, 32'd1,        32'd2,        5'd0,  32'd0,         1'b1, 1};
    vecs[6]  = '{0, 4'd9,  32'd0,        32'd1,        5'd4,  32'h10,        1'b0, 1};
    vecs[7]  = '{1, 4'd4,  32'hAAAA5555, 32'hAAAA5555, 5'd0,  32'd0,         1'b1, 1};
    vecs[8]  = '{0, 4'd8,  32'h10000,    32'h10000,    5'd0,  32'd0,         1'b1, MUL};
    vecs[9]  = '{1, 4'd6,  32'hFFFFFFFF, 32'd1,        5'd0,  32'd1,         1'b0, 1};
    vecs[10] = '{0, 4'd11, 32'd0,        32'h80000000, 5'd31, 32'hFFFFFFFF,  1'b0, 1};
    vecs[11] = '{1, 4'd14, 32'd0,        32'h1234,     5'd0,  32'h12340000,  1'b0, 1};

    // Reset, checked before any clock edge
    reset = 1'b1;
    drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    drive_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    resp_ready0 = 1'b0;
    resp_ready1 = 1'b0;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("idle_no_grant0", req_ready0, 0);
    check("idle_no_grant1", req_ready1, 0);

    // Vector table
    foreach (vecs[i])
      run_txn(vecs[i].who, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh,
              vecs[i].res, vecs[i].zero, vecs[i].lat, $sformatf("vec%0d", i));

    // Continuous contention: grants must alternate starting with requester 0
    @(negedge clk);
    drive_req(0, 1'b1, 4'd1, 32'd9, 32'd9, 5'd0);
    drive_req(1, 1'b1, 4'd2, 32'hF0, 32'h0F, 5'd0);
    resp_ready0 = 1'b1;
    resp_ready1 = 1'b1;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      #1;
      if (req_ready0) order.push_back(0);
      if (req_ready1) order.push_back(1);
      if (resp_valid0 || resp_valid1) begin
        check("contend_result", resp_result, 0);
        check("contend_zero", resp_zero, 1);
      end
      if (order.size() < 4) @(negedge clk);
    end
    @(posedge clk);
    #1;
    drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    drive_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    repeat (3) begin
      @(negedge clk);
      #1;
      if (resp_valid0 || resp_valid1) begin
        check("contend_tail_result", resp_result, 0);
        check("contend_tail_zero", resp_zero, 1);
      end
    end
    resp_ready0 = 1'b0;
    resp_ready1 = 1'b0;
    check("contend_grants", order.size(), 4);
    for (int i = 0; i < order.size() && i < 4; i++)
      check($sformatf("contend_order%0d", i), order[i], i % 2);
    g0 += 2;
    g1 += 2;

    // Response back-pressure on requester 1 with requester 0 pending
    @(negedge clk);
    drive_req(1, 1'b1, 4'd3, 32'd1, 32'd2, 5'd0);
    #1;
    check("bp_grant1", req_ready1, 1);
    @(posedge clk);
    #1;
    g1++;
    drive_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    drive_req(0, 1'b1, 4'd0, 32'd7, 32'd8, 5'd0);
    resp_ready0 = 1'b1;
    wait_resp(1, 32'd3, "bp");
    held = resp_result;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("bp_valid_held", resp_valid1, 1);
      check("bp_result_held", resp_result, 32'd3);
      check("bp_no_grant0", req_ready0, 0);
      check("bp_no_resp0", resp_valid0, 0);
    end
    resp_ready1 = 1'b1;
    @(posedge clk);
    #1;
    resp_ready1 = 1'b0;
    check("bp_grant0_after", req_ready0, 1);
    @(posedge clk);
    #1;
    g0++;
    drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    wait_resp(0, 32'd15, "bp_second");
    @(posedge clk);
    #1;
    resp_ready0 = 1'b0;
    check("bp_second_done", resp_valid0, 0);

    // Asynchronous reset in the middle of a multiply owned by requester 1
    @(negedge clk);
    drive_req(1, 1'b1, 4'd8, 32'd5, 32'd6, 5'd0);
    #1;
    check("rst_grant1", req_ready1, 1);
    @(posedge clk);
    #1;
    drive_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    #2;
    check("rst_exec_state", dbg_state, 1);
    reset = 1'b1;
    #1;
    g0 = 0;
    g1 = 0;
    check_reset_outputs("async_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1;
      check("rst_no_resp0", resp_valid0, 0);
      check("rst_no_resp1", resp_valid1, 0);
    end
    drive_req(0, 1'b1, 4'd0, 32'd1, 32'd1, 5'd0);
    drive_req(1, 1'b1, 4'd0, 32'd3, 32'd3, 5'd0);
    #1;
    check("rst_next_grant0", req_ready0, 1);
    check("rst_next_grant1", req_ready1, 0);
    @(posedge clk);
    #1;
    g0++;
    drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    drive_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    resp_ready0 = 1'b1;
    wait_resp(0, 32'd2, "rst_next");
    @(posedge clk);
    #1;
    resp_ready0 = 1'b0;

    // Three grants to requester 0 and two to requester 1 since reset
    run_txn(0, 4'd0, 32'd1, 32'd2, 5'd0, 32'd3, 1'b0, 1, "stat_a");
    run_txn(0, 4'd7, 32'd1, 32'd2, 5'd0, 32'd1, 1'b0, 1, "stat_b");
    run_txn(1, 4'd5, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1, "stat_c");
    run_txn(1, 4'd10, 32'd0, 32'h100, 5'd8, 32'd1, 1'b0, 1, "stat_d");
`ifdef ALU_ARB_STATS_EN
    check("stat_count0", grant_count0, 3);
    check("stat_count1", grant_count1, 2);
`endif

    // Randomized run against the reference model, from a fresh reset
    @(negedge clk);
    reset = 1'b1;
    #1;
    g0 = 0;
    g1 = 0;
    check_reset_outputs("rand_reset");
    @(negedge clk);
    reset = 1'b0;
    m_busy = 0; m_owner = 0; m_prio = 0; m_elapsed = 0; m_lat = 0;
    last_op = 4'd0; last_a = 32'd0; last_b = 32'd0; last_sh = 5'd0;
    pv[0] = 0;
    pv[1] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!pv[i]) begin
          p_op[i] = pick_op();
          p_a[i]  = $urandom;
          p_b[i]  = ($urandom_range(0, 3) == 0) ? p_a[i] : $urandom;
          p_sh[i] = 5'($urandom);
          pv[i]   = ($urandom_range(0, 2) == 0);
        end else if ($urandom_range(0, 15) == 0) begin
          pv[i] = 0;
        end
        drive_req(i, pv[i], p_op[i], p_a[i], p_b[i], p_sh[i]);
      end
      resp_ready0 = ($urandom_range(0, 2) != 0);
      resp_ready1 = ($urandom_range(0, 2) != 0);
      #1;
      e0 = 0;
      e1 = 0;
      if (!m_busy) begin
        if (pv[0] && pv[1]) begin
          e0 = !m_prio;
          e1 = m_prio;
        end else begin
          e0 = pv[0];
          e1 = pv[1];
        end
      end
      check("rand_ready0", req_ready0, e0);
      check("rand_ready1", req_ready1, e1);
      ev = m_busy && (m_elapsed >= m_lat);
      check("rand_resp_valid0", resp_valid0, ev && !m_owner);
      check("rand_resp_valid1", resp_valid1, ev && m_owner);
      if (ev && exp_q.size() > 0) begin
        check("rand_result", resp_result, exp_q[0][31:0]);
        check("rand_zero", resp_zero, exp_q[0][32]);
      end
      check("rand_alu_op", alu_control, last_op);
      check("rand_alu_a", alu_a, last_a);
      check("rand_alu_b", alu_b, last_b);
      check("rand_alu_shamt", alu_shamt, last_sh);
      if (e0 || e1) begin
        w = e1 ? 1 : 0;
        m_busy = 1;
        m_owner = (w == 1);
        m_elapsed = 0;
        m_lat = (p_op[w] == 4'd8) ? MUL : 1;
        exp_q.push_back({(exp_res(p_op[w], p_a[w], p_b[w], p_sh[w]) == 32'd0),
                         exp_res(p_op[w], p_a[w], p_b[w], p_sh[w])});
        last_op = p_op[w]; last_a = p_a[w]; last_b = p_b[w]; last_sh = p_sh[w];
        pv[w] = 0;
        if (w == 0) g0++; else g1++;
      end else if (m_busy) begin
        if (ev) begin
          if ((m_owner ? resp_ready1 : resp_ready0) == 1'b1) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            m_busy = 0;
            m_prio = !m_owner;
          end
        end else begin
          m_elapsed++;
        end
      end
    end
`ifdef ALU_ARB_STATS_EN
    @(negedge clk);
    check("rand_count0", grant_count0, 16'(g0));
    check("rand_count1", grant_count1, 16'(g1));
`endif
    check("rand_activity", (g0 > 20) && (g1 > 20), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
